test_dut: RTL and testbench

TEST_DUT -- requirements
Module: test_dut

---
 rtl/test_pkg.sv | 11 +
 rtl/test_if.sv | 17 +
 rtl/test_rom.sv | 24 ++
 rtl/test_dut.sv | 49 ++++
 tb/tb_test_dut.sv | 133 +++++++++++++
 5 files changed

// File: rtl/test_pkg.sv
// Shared defaults and types for the memory player.
package test_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  // One stored word at the default width.
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : test_pkg

// File: rtl/test_if.sv
// Read bus between the address/reset logic and the ROM.
// Handshake: there is no valid/ready pair. The master presents addr and clr
// every cycle; the slave registers a word on every rising edge, so data
// always belongs to the addr/clr sampled on the previous edge.
interface test_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] addr;
  logic              clr;
  logic [DATA_W-1:0] data;

  modport master (output addr, output clr, input data);
  modport slave  (input addr, input clr, output data);

endinterface : test_if

// File: rtl/test_rom.sv
// Registered synchronous read of the word store; never writes the store.
module test_rom #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] mem [0:DEPTH-1],
  test_if.slave             rd
);

  logic [DATA_W-1:0] data_q;

  // Capture the addressed word each edge; clr forces a zero word instead.
  always_ff @(posedge clk) begin
    if (rd.clr) begin
      data_q <= '0;
    end else begin
      data_q <= mem[rd.addr];
    end
  end

  assign rd.data = data_q;

endmodule : test_rom

// File: rtl/test_dut.sv
// Free-running memory player: streams mem[0], mem[1], ... onto o, wrapping
// at DEPTH-1 without a gap. The word store lives here so it can be preloaded
// as test_dut.mem; reset clears the pointer and output but never the store.
module test_dut
  import test_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] o
);

  // Read-only contents, loaded from outside; nothing in the design writes it.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  test_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rd_bus ();

  // Next pointer; DEPTH is a power of two so the natural overflow wraps.
  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
  end

  // Read pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign rd_bus.addr = addr_q;
  assign rd_bus.clr  = rst;

  test_rom #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rom (
    .clk (clk),
    .mem (mem),
    .rd  (rd_bus.slave)
  );

  assign o = rd_bus.data;

endmodule : test_dut

// File: tb/tb_test_dut.sv
// Directed bench for the memory player: preload through test_dut.mem,
// drive reset patterns and compare o against hand-computed words.
module tb_test_dut;
  import test_pkg::*;

  logic  clk;
  logic  rst;
  word_t o;

  int n_cmp;
  int n_err;

  test_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) mon_if ();

  assign mon_if.addr = '0;
  assign mon_if.clr  = rst;
  assign mon_if.data = o;

  test_dut #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .o   (o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Comparison helper: counts every check, reports mismatches.
  task automatic check(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  word_t exp_play [0:8];
  word_t exp_tog  [0:5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    exp_play = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10};
    exp_tog  = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12};

    // Preload entries 2..5, reset for two edges, then play.
    dut.mem[2] = 8'hA1;
    dut.mem[3] = 8'hB2;
    dut.mem[4] = 8'hC3;
    dut.mem[5] = 8'hD4;
    step();
    check("rst_edge1", mon_if.data, 8'h00);
    step();
    check("rst_edge2", mon_if.data, 8'h00);
    rst = 1'b0;
    step();
    step();
    step();
    check("play_edge3", o, 8'hA1);
    step();
    check("play_edge4", o, 8'hB2);
    step();
    check("play_edge5", o, 8'hC3);
    step();
    check("play_edge6", o, 8'hD4);

    // Long reset hold: output stays zero, store survives.
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("hold_%0d", i), o, 8'h00);
    end
    check("keep_mem2", dut.mem[2], 8'hA1);
    check("keep_mem3", dut.mem[3], 8'hB2);
    check("keep_mem4", dut.mem[4], 8'hC3);
    check("keep_mem5", dut.mem[5], 8'hD4);

    // Full preload 10..17, play through the wrap.
    for (int i = 0; i < 8; i++) dut.mem[i] = word_t'(8'h10 + i);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("wrap_%0d", i), o, exp_play[i]);
    end
    step();
    check("run_11", o, 8'h11);
    step();
    check("run_12", o, 8'h12);
    step();
    check("run_13", o, 8'h13);

    // One-edge reset mid-sequence restarts from mem[0].
    rst = 1'b1;
    step();
    check("mid_rst", o, 8'h00);
    rst = 1'b0;
    step();
    check("restart_10", o, 8'h10);
    step();
    check("restart_11", o, 8'h11);
    step();
    check("restart_12", o, 8'h12);

    // Reset toggled every three edges: never beyond mem[2].
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) begin
        rst = (i < 3);
        step();
        check($sformatf("toggle_%0d_%0d", r, i), o, exp_tog[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_test_dut
